// File: rtl/base_align_left.sv
// Streaming byte realigner: drops the first i_samt bytes of a packet and packs the
// remaining bytes toward byte 0 across beat boundaries. One held beat, one packet in flight.
module base_align_left #(
    parameter int width = 128,
    localparam int bwidth = width / 8,
    localparam int swidth = $clog2(bwidth)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              i_v,
    output logic              i_r,
    input  logic [0:width-1]  i_d,
    input  logic              i_e,
    input  logic [0:swidth-1] i_samt,
    output logic              o_v,
    input  logic              o_r,
    output logic [0:width-1]  o_d,
    output logic              o_e,
    output logic [0:swidth]   o_c
);

    localparam logic [swidth:0] bw_c = (swidth + 1)'(bwidth);

    logic [0:width-1]  h_d_q;
    logic [0:width-1]  h_d_d;
    logic              h_v_q;
    logic              h_v_d;
    logic              h_e_q;
    logic              h_e_d;
    logic [swidth-1:0] s_q;
    logic [swidth-1:0] s_d;
    logic              f_q;
    logic              f_d;

    logic              in_x_s;
    logic              out_x_s;
    logic [swidth+3:0] lsh_s;
    logic [swidth+3:0] rsh_s;

    // Handshake and realigned output beat built from the held beat plus the head of i_d.
    always_comb begin
        in_x_s  = 1'b0;
        out_x_s = 1'b0;
        i_r     = 1'b0;
        o_v     = 1'b0;
        o_d     = {width{1'b0}};
        o_e     = 1'b0;
        o_c     = {(swidth + 1){1'b0}};
        // Byte 0 sits in the most significant bits, so a value left shift moves bytes toward 0.
        lsh_s   = {1'b0, s_q, 3'b000};
        rsh_s   = {bw_c - {1'b0, s_q}, 3'b000};

        i_r     = !h_v_q || (!h_e_q && o_r);
        o_v     = h_v_q && (h_e_q || i_v);
        in_x_s  = i_v && i_r;
        out_x_s = o_v && o_r;

        if (!h_v_q) begin
            o_d = {width{1'b0}};
            o_e = 1'b0;
            o_c = {(swidth + 1){1'b0}};
        end else if (h_e_q) begin
            o_d = h_d_q << lsh_s;
            o_e = 1'b1;
            o_c = bw_c - {1'b0, s_q};
        end else begin
            // A shift of a full beat (s_q == 0) yields zero, leaving a plain delay.
            o_d = (h_d_q << lsh_s) | (i_d >> rsh_s);
            o_e = 1'b0;
            o_c = bw_c;
        end
    end

    // Next-state: draining the end beat takes priority and blocks input for that cycle.
    always_comb begin
        h_d_d = h_d_q;
        h_v_d = h_v_q;
        h_e_d = h_e_q;
        s_d   = s_q;
        f_d   = f_q;

        if (out_x_s && h_e_q) begin
            h_v_d = 1'b0;
            h_e_d = 1'b0;
            f_d   = 1'b1;
        end else if (in_x_s) begin
            h_d_d = i_d;
            h_e_d = i_e;
            h_v_d = 1'b1;
            if (f_q) begin
                s_d = i_samt;
                f_d = 1'b0;
            end else begin
                s_d = s_q;
                f_d = f_q;
            end
        end else begin
            h_v_d = h_v_q;
        end
    end

    // State registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            h_d_q <= {width{1'b0}};
            h_v_q <= 1'b0;
            h_e_q <= 1'b0;
            s_q   <= {swidth{1'b0}};
            f_q   <= 1'b1;
        end else begin
            h_d_q <= h_d_d;
            h_v_q <= h_v_d;
            h_e_q <= h_e_d;
            s_q   <= s_d;
            f_q   <= f_d;
        end
    end

endmodule

// File: tb/tb_base_align_left.sv
// Scoreboard bench for base_align_left at width=32: expected beats are computed from the
// input packet byte stream and compared as the design emits them.
module tb_base_align_left;

    localparam int W = 32;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        i_v = 1'b0;
    logic        i_r;
    logic [31:0] i_d = 32'h0;
    logic        i_e = 1'b0;
    logic [1:0]  i_samt = 2'd0;
    logic        o_v;
    logic        o_r = 1'b1;
    logic [31:0] o_d;
    logic        o_e;
    logic [2:0]  o_c;

    typedef struct packed {
        logic [31:0] d;
        logic        e;
        logic [2:0]  c;
    } beat_t;

    beat_t       exp_q[$];
    logic [31:0] pkt[$];
    int          errors = 0;
    int          checks = 0;
    logic        bp_done;

    base_align_left #(.width(W)) dut (
        .clk(clk), .reset_n(reset_n),
        .i_v(i_v), .i_r(i_r), .i_d(i_d), .i_e(i_e), .i_samt(i_samt),
        .o_v(o_v), .o_r(o_r), .o_d(o_d), .o_e(o_e), .o_c(o_c)
    );

    always #5 clk = ~clk;

    // Byte k of a word is bits [31-8k -: 8]; drop samt bytes, repack into the same beat count.
    task automatic push_expected(input int samt);
        logic [7:0] bs[$];
        int n;
        beat_t x;
        n = pkt.size();
        for (int b = 0; b < n; b++)
            for (int k = 0; k < 4; k++) bs.push_back(pkt[b][31-8*k -: 8]);
        for (int k = 0; k < samt; k++) void'(bs.pop_front());
        for (int j = 0; j < n; j++) begin
            x.d = 32'h0;
            for (int k = 0; k < 4; k++)
                if (bs.size() > 0) x.d[31-8*k -: 8] = bs.pop_front();
            x.e = (j == n - 1);
            x.c = (j == n - 1) ? 3'(4 - samt) : 3'd4;
            exp_q.push_back(x);
        end
    endtask

    task automatic monitor();
        logic  hold_p;
        beat_t held;
        hold_p = 1'b0;
        held = '0;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                hold_p = 1'b0;
            end else begin
                if (hold_p) begin
                    checks++;
                    if (o_v !== 1'b1 || {o_d, o_e, o_c} !== held) begin
                        errors++;
                        $display("FAIL hold_stable: o_v=%0b o_d=%h o_e=%0b o_c=%0d, required o_v=1 o_d=%h o_e=%0b o_c=%0d",
                                 o_v, o_d, o_e, o_c, held.d, held.e, held.c);
                    end
                end
                if (o_v) begin
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_beat: o_d=%h o_e=%0b o_c=%0d, required no beat", o_d, o_e, o_c);
                    end else begin
                        if ({o_d, o_e, o_c} !== exp_q[0]) begin
                            errors++;
                            $display("FAIL out_beat: o_d=%h o_e=%0b o_c=%0d, required o_d=%h o_e=%0b o_c=%0d",
                                     o_d, o_e, o_c, exp_q[0].d, exp_q[0].e, exp_q[0].c);
                        end
                        if (!o_r && !exp_q[0].e) begin
                            checks++;
                            if (i_r !== 1'b0) begin
                                errors++;
                                $display("FAIL ir_while_held: i_r=%0b, required 0", i_r);
                            end
                        end
                        if (o_r) void'(exp_q.pop_front());
                    end
                end
                hold_p = o_v && !o_r;
                held   = {o_d, o_e, o_c};
            end
        end
    endtask

    task automatic send_pkt(input int samt, output int w_first, output int w_rest);
        int w;
        push_expected(samt);
        w_first = 0;
        w_rest  = 0;
        for (int b = 0; b < pkt.size(); b++) begin
            i_v    = 1'b1;
            i_d    = pkt[b];
            i_e    = (b == pkt.size() - 1);
            i_samt = (b == 0) ? 2'(samt) : ~2'(samt);
            w = 0;
            forever begin
                @(negedge clk);
                if (i_r) begin
                    @(posedge clk); #1;
                    break;
                end
                @(posedge clk); #1;
                w++;
                if (w >= 200) begin
                    checks++;
                    errors++;
                    $display("FAIL accept_timeout: beat %0d waited %0d cycles, required acceptance", b, w);
                    break;
                end
            end
            if (b == 0) w_first = w;
            else if (w > w_rest) w_rest = w;
        end
        i_v = 1'b0;
        i_e = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 300) begin
            @(posedge clk); #1;
            n++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s_drain: %0d beats outstanding, required 0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_reset();
        #2;
        checks++;
        if ({o_v, o_e, o_c, o_d} !== 37'h0) begin
            errors++;
            $display("FAIL reset_outputs: o_v=%0b o_e=%0b o_c=%0d o_d=%h, required all 0", o_v, o_e, o_c, o_d);
        end
        @(posedge clk); #1;
        reset_n = 1'b1;
        @(negedge clk);
        checks++;
        if (i_r !== 1'b1 || o_v !== 1'b0) begin
            errors++;
            $display("FAIL reset_ready: i_r=%0b o_v=%0b, required i_r=1 o_v=0", i_r, o_v);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_shift1();
        int wf, wr;
        pkt = '{32'h00112233, 32'h44556677};
        send_pkt(1, wf, wr);
        wait_drain("shift1");
    endtask

    task automatic test_samt0();
        int wf, wr;
        pkt = '{32'hA0A1A2A3, 32'hB0B1B2B3, 32'hC0C1C2C3};
        send_pkt(0, wf, wr);
        checks++;
        if (wf != 0 || wr != 0) begin
            errors++;
            $display("FAIL samt0_bubbles: first wait=%0d max mid wait=%0d, required 0 and 0", wf, wr);
        end
        wait_drain("samt0");
    endtask

    task automatic test_single();
        int wf, wr;
        o_r = 1'b0;
        pkt = '{32'hAABBCCDD};
        send_pkt(3, wf, wr);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checks++;
            if (i_r !== 1'b0 || o_v !== 1'b1) begin
                errors++;
                $display("FAIL single_held: i_r=%0b o_v=%0b, required i_r=0 o_v=1", i_r, o_v);
            end
            @(posedge clk); #1;
        end
        o_r = 1'b1;
        wait_drain("single");
        @(negedge clk);
        checks++;
        if (i_r !== 1'b1) begin
            errors++;
            $display("FAIL single_ready_after: i_r=%0b, required 1", i_r);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_backpressure();
        int wf, wr;
        int hc;
        o_r = 1'b0;
        bp_done = 1'b0;
        pkt = '{32'h00112233, 32'h44556677};
        fork
            begin
                send_pkt(1, wf, wr);
                wait_drain("backpressure");
                bp_done = 1'b1;
            end
            begin
                hc = 0;
                while (!bp_done) begin
                    @(posedge clk); #2;
                    if (o_v && hc < 5) begin
                        o_r = 1'b0;
                        hc++;
                    end else if (o_v) begin
                        o_r = 1'b1;
                        hc = 0;
                    end else begin
                        o_r = 1'b0;
                        hc = 0;
                    end
                end
            end
        join
        @(posedge clk); #1;
        o_r = 1'b1;
    endtask

    task automatic test_back_to_back();
        int wf1, wr1, wf2, wr2;
        pkt = '{32'h01020304, 32'h05060708};
        send_pkt(2, wf1, wr1);
        pkt = '{32'h11121314, 32'h15161718};
        send_pkt(1, wf2, wr2);
        checks++;
        if (wf1 != 0 || wr1 != 0 || wf2 != 1 || wr2 != 0) begin
            errors++;
            $display("FAIL b2b_bubbles: waits p1=%0d/%0d p2=%0d/%0d, required 0/0 1/0", wf1, wr1, wf2, wr2);
        end
        wait_drain("b2b");
    endtask

    task automatic test_reset_mid();
        int wf, wr;
        pkt = '{32'h11223344, 32'h55667788};
        push_expected(2);
        i_v = 1'b1; i_d = pkt[0]; i_e = 1'b0; i_samt = 2'd2;
        @(posedge clk); #1;
        i_d = pkt[1]; i_e = 1'b1; i_samt = 2'd1; o_r = 1'b0;
        @(negedge clk);
        checks++;
        if (o_v !== 1'b1) begin
            errors++;
            $display("FAIL midreset_pre: o_v=%0b, required 1", o_v);
        end
        #1 reset_n = 1'b0;
        #1;
        checks++;
        if ({o_v, o_e, o_c, o_d} !== 37'h0) begin
            errors++;
            $display("FAIL midreset_async: o_v=%0b o_e=%0b o_c=%0d o_d=%h, required all 0", o_v, o_e, o_c, o_d);
        end
        i_v = 1'b0; i_e = 1'b0;
        exp_q.delete();
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset_n = 1'b1;
        o_r = 1'b1;
        pkt = '{32'hCAFEBABE, 32'h12345678};
        send_pkt(0, wf, wr);
        wait_drain("midreset");
    endtask

    task automatic test_random();
        int wf, wr, n;
        for (int p = 0; p < 4; p++) begin
            n = $urandom_range(1, 4);
            pkt.delete();
            for (int b = 0; b < n; b++) pkt.push_back($urandom);
            send_pkt($urandom_range(0, 3), wf, wr);
        end
        wait_drain("random");
    endtask

    initial begin
        fork
            monitor();
        join_none
        test_reset();
        test_shift1();
        test_samt0();
        test_single();
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/base_align_left.md
Name: base_align_left

Overview:
- Streaming byte realigner. Drops the first i_samt bytes of a packet and packs every following byte toward index 0 across beat boundaries.
- Counterpart of the combinational right shifter. Used where payload that was shifted right on the way out must be recovered aligned on the way back, e.g. read-data return with a non-aligned start offset.
- Valid/ready in, valid/ready out. One holding register, one packet in flight.

Parameters:
- width, 128, data width in bits; must be a multiple of 8.
- bwidth, width/8, bytes per beat (derived).
- swidth, $clog2(bwidth), width of the byte shift amount (derived).

Ports:
- clk  input  1  clock; all state on rising edge.
- reset_n  input  1  asynchronous active-low reset.
- i_v  input  1  input beat valid.
- i_r  output  1  input beat ready.
- i_d  input  [0:width-1]  input data. Byte k occupies bits 8k..8k+7.
- i_e  input  1  last beat of packet.
- i_samt  input  [0:swidth-1]  leading bytes to drop. Sampled only on the first beat of a packet.
- o_v  output  1  output beat valid.
- o_r  input  1  output beat ready.
- o_d  output  [0:width-1]  realigned data.
- o_e  output  1  last output beat of packet.
- o_c  output  [0:swidth]  valid byte count of the beat. Equals bwidth except on the last beat.

Behaviour:
- State: holding register h_d, flags h_v and h_e, latched shift s_q, first-beat flag f_q (1 = next accepted beat starts a packet).
- Reset (async, reset_n=0):
  - h_v=0, h_e=0, s_q=0, f_q=1, h_d=0.
  - Outputs: o_v=0, o_e=0, o_c=0, o_d=0, i_r=1 once reset deasserts.
- Handshake: a transfer occurs on a cycle with v&&r. Upstream holds i_v, i_d, i_e and i_samt stable until accepted. o_v never drops without o_r. o_d, o_e and o_c stay stable while o_v&&!o_r.
- i_r:
  - =1 when h_v=0.
  - =o_r when h_v=1 and h_e=0 (an input is accepted only together with the output it completes).
  - =0 when h_v=1 and h_e=1.
- o_v = h_v && (h_e || i_v).
- o_d when h_e=0:
  - bytes 0..bwidth-1-s_q = h_d bytes s_q..bwidth-1.
  - bytes bwidth-s_q..bwidth-1 = i_d bytes 0..s_q-1.
  - o_e=0, o_c=bwidth.
- o_d when h_e=1:
  - same upper part taken from h_d; tail bytes = 0.
  - o_e=1, o_c=bwidth-s_q.
- Load rule: an accepted input beat writes h_d, and h_e<=i_e, h_v<=1. If f_q=1, also s_q<=i_samt and f_q<=0.
- On an accepted output with h_e=1: h_v<=0, h_e<=0, f_q<=1. No input is accepted that cycle.
- s_q=0: pure one-beat delay. o_c=bwidth on the last beat.
- Latency and count:
  - First output appears the cycle the second input beat is presented. For a single-beat packet, it appears one cycle after acceptance.
  - N input beats produce exactly N output beats; no flush beat.
- Throughput: 1 beat/cycle in mid-packet. One bubble on i_r per packet while the end beat drains.
- Input beat with i_e=1 and f_q=1 (single-beat packet) is legal.
- Mid-packet reset drops the held beat and clears all state. The next accepted beat is treated as a packet start.

Test Plan:
1. width=32, samt=1, input beats 0x00112233, 0x44556677(e) with o_r=1 -> outputs 0x11223344 (o_c=4), then 0x55667700 (o_e=1, o_c=3).
2. width=32, samt=0, three beats A, B, C(e) -> outputs A, B, C one cycle delayed, o_c=4 on each, o_e only on C, no bubbles mid-packet.
3. width=32, samt=3, single beat 0xAABBCCDD(e) -> one output 0xDD000000, o_e=1, o_c=1. i_r=0 until it is taken.
4. Backpressure: scenario 1 with o_r=0 for 5 cycles on each beat -> o_d/o_e/o_c stable, i_r=0 while held beat is not the end beat, no beat lost or duplicated.
5. Back-to-back packets: samt=2 then samt=1 -> second packet uses samt=1 (latched on its first beat). Exactly one i_r bubble between packets.
6. reset_n pulsed low while h_v=1 mid-packet -> o_v=0 immediately (async). A new packet afterward with samt=0 passes through unaltered.
